ff_ranker: RTL

Parametrised fastest-finger-first arbiter for the quiz console. It synchronises N raw player buttons and opens a response window on `arm`. It records the first RANKS distinct players to press, in order, and closes the window when the ranks fill, when no eligible player remains, or on timeout. Players holding their button when the window opens are flagged as false starts and excluded. It sits between the button pads and the display/scoring logic.

---
 rtl/ff_ranker_pkg.sv | 43 ++++
 rtl/ff_ranker_if.sv | 33 +++
 rtl/ff_ranker_sync_edge.sv | 29 ++
 rtl/ff_ranker.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ff_ranker_pkg.sv
// ff_pkg: shared types and helpers for the fastest-finger-first ranker.
//   state_t      : FSM encoding (IDLE 00, ARMED 01, CLOSED 10; 11 is illegal)
//   idx_w()      : player index width, max(1, clog2(n))
//   rank_assign(): priority capture of eligible presses into free rank slots
package ff_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ARMED  = 2'b01,
      S_CLOSED = 2'b10
   } state_t;

   localparam int MAX_N  = 16;
   localparam int MAX_IW = 4;

   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // idx[k] is the player taking the k-th free slot this cycle; taken marks
   // every player that got a slot, cnt is how many slots were consumed.
   typedef struct packed {
      logic [MAX_N-1:0][MAX_IW-1:0] idx;
      logic [MAX_N-1:0]             taken;
      logic [4:0]                   cnt;
   } assign_t;

   // Lowest index wins; presses beyond the free slots are simply not taken.
   function automatic assign_t rank_assign(input logic [MAX_N-1:0] elig,
                                           input logic [4:0]       free);
      assign_t res;
      res = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (elig[i] && (res.cnt < free)) begin
            res.idx[res.cnt[3:0]] = 4'(i);
            res.taken[i]          = 1'b1;
            res.cnt               = res.cnt + 5'd1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ff_ranker_if.sv
// ff_ranker_if: control and result bundle of the ranker.
//   arm, clear, buttons            : console -> ranker
//   rank_idx, rank_valid,
//   ranked_mask, false_start,
//   busy, done, timed_out          : ranker -> display/scoring
interface ff_ranker_if #(
   parameter int N_PLAYERS = 4,
   parameter int RANKS     = 2
);
   import ff_pkg::*;
   localparam int IDX_W = idx_w(N_PLAYERS);

   logic                   arm;
   logic                   clear;
   logic [N_PLAYERS-1:0]   buttons;
   logic [RANKS*IDX_W-1:0] rank_idx;
   logic [RANKS-1:0]       rank_valid;
   logic [N_PLAYERS-1:0]   ranked_mask;
   logic [N_PLAYERS-1:0]   false_start;
   logic                   busy;
   logic                   done;
   logic                   timed_out;

   modport master (
      output arm, clear, buttons,
      input  rank_idx, rank_valid, ranked_mask, false_start, busy, done, timed_out
   );

   modport slave (
      input  arm, clear, buttons,
      output rank_idx, rank_valid, ranked_mask, false_start, busy, done, timed_out
   );
endinterface

// File: rtl/ff_ranker_sync_edge.sv
// ff_sync_edge: per-bit 2-flop synchroniser plus rising-edge detector.
//   din   : raw asynchronous inputs
//   sync  : synchronised level (2 edges after sampling)
//   press : one-cycle pulse on a synchronised 0->1 transition
module ff_sync_edge #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] sync,
   output logic [W-1:0] press
);
   logic [W-1:0] meta, prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign press = sync & ~prev;
endmodule

// File: rtl/ff_ranker.sv
// ff_ranker: fastest-finger-first arbiter.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : ff_ranker_if.slave (arm/clear/buttons in, ranking results out)
// Records the first RANKS distinct eligible players in press order, flags
// players holding their button at arm as false starts, and closes the window
// on full ranks, exhaustion of eligible players, or timeout.
module ff_ranker import ff_pkg::*; #(
   parameter int N_PLAYERS   = 4,
   parameter int RANKS       = 2,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst,
   ff_ranker_if.slave bus
);
   localparam int IDX_W = idx_w(N_PLAYERS);
   localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   state_t                        state;
   logic [TW-1:0]                 timer;
   logic [RANKS-1:0][IDX_W-1:0]   idx_q, idx_n;
   logic [RANKS-1:0]              valid_q, valid_n;
   logic [N_PLAYERS-1:0]          mask_q, mask_n, fs_q;
   logic                          busy_q, done_q, to_q;

   logic [N_PLAYERS-1:0]          sync, press, elig;
   logic [4:0]                    filled, free, slot;
   assign_t                       asg;
   logic                          full, exhausted, tmo;

   ff_sync_edge #(.W(N_PLAYERS)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.buttons),
      .sync  (sync),
      .press (press)
   );

   assign elig = press & ~fs_q & ~mask_q;

   // Ranks fill strictly in order, so the count of valid bits is the next slot.
   always_comb begin
      filled = '0;
      for (int r = 0; r < RANKS; r++) filled = filled + {4'd0, valid_q[r]};
   end
   assign free = 5'(RANKS) - filled;
   assign asg  = rank_assign(MAX_N'(elig), free);

   always_comb begin
      idx_n   = idx_q;
      valid_n = valid_q;
      mask_n  = mask_q | asg.taken[N_PLAYERS-1:0];
      slot    = '0;
      for (int r = 0; r < RANKS; r++) begin
         slot = 5'(r) - filled;
         if ((5'(r) >= filled) && (slot < asg.cnt)) begin
            idx_n[r]   = asg.idx[slot[3:0]][IDX_W-1:0];
            valid_n[r] = 1'b1;
         end
      end
   end

   assign full      = &valid_n;
   assign exhausted = &(mask_n | fs_q);
   assign tmo       = (TIMEOUT_CYC != 0) && (timer == T_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         timer   <= '0;
         idx_q   <= '0;
         valid_q <= '0;
         mask_q  <= '0;
         fs_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else if (bus.clear) begin
         state   <= S_IDLE;
         timer   <= '0;
         idx_q   <= '0;
         valid_q <= '0;
         mask_q  <= '0;
         fs_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_CLOSED: begin
               if (bus.arm) begin
                  state   <= S_ARMED;
                  timer   <= '0;
                  idx_q   <= '0;
                  valid_q <= '0;
                  mask_q  <= '0;
                  fs_q    <= sync;    // anyone already holding is disqualified
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  to_q    <= 1'b0;
               end
            end
            S_ARMED: begin
               idx_q   <= idx_n;      // captures in the closing cycle are kept
               valid_q <= valid_n;
               mask_q  <= mask_n;
               timer   <= timer + 1'b1;
               if (full || exhausted || tmo) begin
                  state  <= S_CLOSED;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  to_q   <= tmo;
               end
            end
            default: begin
               state   <= S_IDLE;
               timer   <= '0;
               idx_q   <= '0;
               valid_q <= '0;
               mask_q  <= '0;
               fs_q    <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               to_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rank_idx    = idx_q;
   assign bus.rank_valid  = valid_q;
   assign bus.ranked_mask = mask_q;
   assign bus.false_start = fs_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timed_out   = to_q;
endmodule
